// File: rtl/token_drop_controller.sv
`default_nettype none
// ============================================================================
// Module   : token_drop_controller
// Purpose  : Connect-four drop sequencer: accepts column drops, writes the
//            board, then checks for a win or a full-board draw.
// Revision : 1.0 - initial release
// ============================================================================
module token_drop_controller #(
   parameter int COLS = 7,
   parameter int ROWS = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     new_game,
   input  logic                     drop_valid,
   input  logic [2:0]               drop_col,
   output logic                     drop_ready,
   input  logic                     win_in,
   output logic [2*COLS*ROWS-1:0]   board,
   output logic [1:0]               player,
   output logic                     drop_done,
   output logic                     drop_err,
   output logic                     game_over,
   output logic [1:0]               winner
);

   localparam logic [5:0] c_cells = 6'(COLS*ROWS);
   localparam logic [2:0] c_cols  = 3'(COLS);
   localparam logic [2:0] c_rows  = 3'(ROWS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_CHECK = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [3*COLS-1:0]  r_heights;
   logic [2:0]         r_col;
   logic [5:0]         r_moves;
   logic [2:0]         w_req_height;
   logic [2:0]         w_cur_height;
   logic [6:0]         w_bit_idx;
   logic               w_accept;
   logic               w_col_ok;

   // Height lookup for the requested column and for the captured column
   always_comb begin
      w_req_height = '0;
      w_cur_height = '0;
      for (int i = 0; i < COLS; i++) begin
         if (drop_col == 3'(i)) w_req_height = r_heights[3*i +: 3];
         if (r_col == 3'(i))    w_cur_height = r_heights[3*i +: 3];
      end
   end

   assign drop_ready = (r_state == S_IDLE);
   assign w_accept   = drop_valid && drop_ready && !new_game;
   assign w_col_ok   = (drop_col < c_cols) && (w_req_height < c_rows);
   assign w_bit_idx  = 7'(32'(r_col) * 12 + 32'(w_cur_height) * 2);

   always_comb begin
      w_next_state = r_state;
      if (new_game) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept && w_col_ok) w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_CHECK;
            S_CHECK: w_next_state = (win_in || r_moves == c_cells) ? S_OVER : S_IDLE;
            S_OVER:  w_next_state = S_OVER;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         board     <= '0;
         r_heights <= '0;
         r_moves   <= '0;
         r_col     <= '0;
         player    <= 2'b01;
         winner    <= 2'b00;
         game_over <= 1'b0;
         drop_done <= 1'b0;
         drop_err  <= 1'b0;
      end else begin
         drop_done <= 1'b0;
         drop_err  <= 1'b0;
         if (new_game) begin
            board     <= '0;
            r_heights <= '0;
            r_moves   <= '0;
            player    <= 2'b01;
            winner    <= 2'b00;
            game_over <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept && w_col_ok)  r_col    <= drop_col;
                  if (w_accept && !w_col_ok) drop_err <= 1'b1;
               end
               S_WRITE: begin
                  if (w_cur_height < c_rows) begin
                     board[w_bit_idx +: 2] <= player;
                     r_moves               <= r_moves + 6'd1;
                  end
                  for (int i = 0; i < COLS; i++) begin
                     if (r_col == 3'(i) && w_cur_height < c_rows)
                        r_heights[3*i +: 3] <= w_cur_height + 3'd1;
                  end
               end
               S_CHECK: begin
                  drop_done <= 1'b1;
                  if (win_in) begin
                     game_over <= 1'b1;
                     winner    <= player;
                  end else if (r_moves == c_cells) begin
                     game_over <= 1'b1;
                     winner    <= 2'b00;
                  end else begin
                     player    <= (player == 2'b01) ? 2'b10 : 2'b01;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_token_drop_controller.sv
`default_nettype none
// Bench for token_drop_controller: board-level reference model checked every
// cycle, plus directed scenarios with literal expectations and random play.
module tb_token_drop_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        new_game = 1'b0;
   logic        drop_valid = 1'b0;
   logic [2:0]  drop_col = 3'd0;
   logic        drop_ready;
   logic        win_in;
   logic [83:0] board;
   logic [1:0]  player;
   logic        drop_done;
   logic        drop_err;
   logic        game_over;
   logic [1:0]  winner;
   bit          win_en = 1'b1;

   int tests = 0;
   int fails = 0;

   token_drop_controller #(.COLS(7), .ROWS(6)) dut (
      .clk(clk), .rst(rst), .new_game(new_game), .drop_valid(drop_valid),
      .drop_col(drop_col), .drop_ready(drop_ready), .win_in(win_in),
      .board(board), .player(player), .drop_done(drop_done),
      .drop_err(drop_err), .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] cell_of(input logic [83:0] b, input int c, input int r);
      return b[2*(6*c+r) +: 2];
   endfunction

   // Four-in-a-row detector over any board image
   function automatic bit has_win(input logic [83:0] b);
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++)
            for (int d = 0; d < 4; d++) begin
               int dx;
               int dy;
               bit all;
               logic [1:0] p;
               dx = (d == 1) ? 0 : 1;
               dy = (d == 0) ? 0 : (d == 3) ? -1 : 1;
               if (c + 3*dx < 7 && r + 3*dy < 6 && r + 3*dy >= 0) begin
                  p   = cell_of(b, c, r);
                  all = (p != 2'b00);
                  for (int k = 1; k < 4; k++)
                     if (cell_of(b, c + k*dx, r + k*dy) != p) all = 1'b0;
                  if (all) return 1'b1;
               end
            end
      return 1'b0;
   endfunction

   assign win_in = win_en && has_win(board);

   // ---------------- reference model ----------------
   int m_cell [7][6];
   int m_player = 1;
   int m_winner = 0;
   int m_moves  = 0;
   int m_busy   = 0;
   int m_col    = 0;
   bit m_over   = 1'b0;
   bit m_done   = 1'b0;
   bit m_err    = 1'b0;

   function automatic int col_height(input int c);
      int h = 0;
      for (int r = 0; r < 6; r++) if (m_cell[c][r] != 0) h++;
      return h;
   endfunction

   function automatic logic [83:0] model_board();
      logic [83:0] b = '0;
      for (int c = 0; c < 7; c++)
         for (int r = 0; r < 6; r++) b[2*(6*c+r) +: 2] = 2'(m_cell[c][r]);
      return b;
   endfunction

   always @(posedge clk) begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (rst || new_game) begin
         for (int c = 0; c < 7; c++) for (int r = 0; r < 6; r++) m_cell[c][r] = 0;
         m_player = 1; m_winner = 0; m_moves = 0; m_busy = 0; m_over = 1'b0;
      end else if (m_busy == 1) begin
         m_cell[m_col][col_height(m_col)] = m_player;
         m_moves++;
         m_busy = 2;
      end else if (m_busy == 2) begin
         m_done = 1'b1;
         m_busy = 0;
         if (win_en && has_win(model_board())) begin
            m_over = 1'b1; m_winner = m_player;
         end else if (m_moves == 42) begin
            m_over = 1'b1; m_winner = 0;
         end else begin
            m_player = 3 - m_player;
         end
      end else if (!m_over && drop_valid) begin
         if (drop_col <= 3'd6 && col_height(int'(drop_col)) < 6) begin
            m_busy = 1; m_col = int'(drop_col);
         end else begin
            m_err = 1'b1;
         end
      end
   end

   task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("board",     board,      model_board());
         check("player",    84'(player), 84'(m_player));
         check("winner",    84'(winner), 84'(m_winner));
         check("game_over", 84'(game_over), 84'(m_over));
         check("drop_done", 84'(drop_done), 84'(m_done));
         check("drop_err",  84'(drop_err),  84'(m_err));
         check("ready",     84'(drop_ready), 84'(!m_over && m_busy == 0));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready();
      int n = 0;
      while (!drop_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!drop_ready) begin
         fails++;
         $display("FAIL ready_timeout: drop_ready stayed 0 at %0t", $time);
      end
   endtask

   task automatic drop_at(input int col);
      wait_ready();
      drop_valid = 1'b1;
      drop_col   = 3'(col);
      @(negedge clk);
      drop_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic pulse_new_game();
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
   endtask

   initial begin
      #2 rst = 1'b1;
      #1;
      check("rst_board",  board, 84'd0);
      check("rst_player", 84'(player), 84'd1);
      check("rst_over",   84'(game_over), 84'd0);
      check("rst_ready",  84'(drop_ready), 84'd1);
      @(negedge clk);
      rst = 1'b0;

      // first accept on the first edge after reset release
      drop_valid = 1'b1; drop_col = 3'd3;
      @(negedge clk);
      drop_valid = 1'b0;
      @(negedge clk);
      check("lat_done_early", 84'(drop_done), 84'd0);
      check("col3_cell", 84'(board[37:36]), 84'd1);
      @(negedge clk);
      check("lat_done", 84'(drop_done), 84'd1);
      check("col3_player", 84'(player), 84'd2);
      pulse_new_game();

      // full column then overflow
      for (int i = 0; i < 6; i++) drop_at(0);
      wait_ready();
      drop_valid = 1'b1; drop_col = 3'd0;
      @(negedge clk);
      drop_valid = 1'b0;
      check("full_err", 84'(drop_err), 84'd1);
      check("full_bits", 84'(board[11:0]), 84'b100110011001);
      check("full_player", 84'(player), 84'd1);
      @(negedge clk);
      check("full_err_pulse", 84'(drop_err), 84'd0);

      // out-of-range column
      drop_valid = 1'b1; drop_col = 3'd7;
      @(negedge clk);
      drop_valid = 1'b0;
      check("col7_err", 84'(drop_err), 84'd1);
      check("col7_ready", 84'(drop_ready), 84'd1);
      @(negedge clk);
      pulse_new_game();

      // vertical win for player 1
      for (int i = 0; i < 7; i++) drop_at(i % 2);
      check("win_over", 84'(game_over), 84'd1);
      check("win_winner", 84'(winner), 84'd1);
      drop_valid = 1'b1; drop_col = 3'd2;
      repeat (3) @(negedge clk);
      check("over_no_err", 84'(drop_err), 84'd0);
      drop_valid = 1'b0;
      pulse_new_game();

      // new_game while the drop is being written
      wait_ready();
      drop_valid = 1'b1; drop_col = 3'd4;
      @(negedge clk);
      drop_valid = 1'b0; new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
      check("ng_board", board, 84'd0);
      check("ng_player", 84'(player), 84'd1);
      check("ng_ready", 84'(drop_ready), 84'd1);
      @(negedge clk);
      check("ng_no_done", 84'(drop_done), 84'd0);

      // reset during CHECK
      drop_valid = 1'b1; drop_col = 3'd5;
      @(negedge clk);
      drop_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_abort_board", board, 84'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // draw: fill the whole board with the win detector muted
      win_en = 1'b0;
      for (int i = 0; i < 41; i++) drop_at(i / 6);
      check("draw_not_yet", 84'(game_over), 84'd0);
      drop_at(6);
      check("draw_over", 84'(game_over), 84'd1);
      check("draw_winner", 84'(winner), 84'd0);
      win_en = 1'b1;
      pulse_new_game();

      // random play
      for (int i = 0; i < 1500; i++) begin
         int r;
         @(negedge clk);
         r = int'($urandom_range(0, 199));
         if (r == 0) begin
            rst = 1'b1;
            drop_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
         end else begin
            new_game   = (r < 4);
            drop_valid = ($urandom_range(0, 2) != 0);
            drop_col   = 3'($urandom_range(0, 7));
         end
      end
      @(negedge clk);
      new_game = 1'b0; drop_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/token_drop_controller.md
TOKEN_DROP_CONTROLLER -- requirements
Module: token_drop_controller

Interface
REQ-001 Parameters SHALL be: COLS, 7, board columns; ROWS, 6, board rows; the block SHALL support only these defaults.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 new_game  input  1  synchronous board clear; takes priority over drop requests.
REQ-006 drop_valid  input  1  drop request.
REQ-007 drop_col  input  3  target column 0..6.
REQ-008 drop_ready  output  1  high only in IDLE.
REQ-009 win_in  input  1  combinational win flag computed from the board output.
REQ-010 board  output  84  cell (c,r) occupies bits [2*(6c+r)+1 : 2*(6c+r)], c = column, r = row, r=0 bottom; encoding 00 empty, 01 player 1, 10 player 2.
REQ-011 player  output  2  side to move, 01 or 10.
REQ-012 drop_done  output  1  one-cycle pulse per accepted, written drop.
REQ-013 drop_err  output  1  one-cycle pulse per rejected request.
REQ-014 game_over  output  1  level, high in OVER.
REQ-015 winner  output  2  00 none/draw, 01 or 10 winning player; valid while game_over.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, CHECK and OVER.
REQ-017 Handshake: accept SHALL occur when drop_valid && drop_ready at a rising edge; drop_col SHALL be captured on acceptance.
REQ-018 A 3-bit height counter per column SHALL track the next free row.
REQ-019 Accepted drop, drop_col <= 6 and height < 6: IDLE -> WRITE.
REQ-020 Accepted drop, drop_col > 6 or column height = 6: drop_err SHALL pulse on the next cycle, the state SHALL remain IDLE, and the board, heights and player SHALL be unchanged.
REQ-021 WRITE SHALL write player into cell (col, height[col]), increment height[col], increment a 6-bit move counter, then go to CHECK.
REQ-022 CHECK SHALL sample win_in, which sees the updated board, and SHALL pulse drop_done.
- win_in=1: go to OVER, winner <= player.
- else if move counter = 42: go to OVER, winner <= 00.
- else: toggle player (01<->10) and go to IDLE.
REQ-023 Latency from acceptance to drop_done SHALL be 2 cycles; the next acceptance SHALL be possible 3 cycles after the previous one.
REQ-024 In OVER, drop requests SHALL be ignored: no drop_err, drop_ready=0, board frozen.
REQ-025 new_game in any state SHALL cause the following on the next edge:
- board, heights and move counter cleared;
- player <= 01, winner <= 00, game_over <= 0;
- state <= IDLE;
- any in-flight drop discarded, with no drop_done or drop_err for it.
REQ-026 new_game together with drop_valid in IDLE: new_game SHALL win and the drop SHALL not be accepted.
REQ-027 win_in SHALL be ignored outside CHECK.
REQ-028 Height counters SHALL saturate at 6 and never wrap.
REQ-029 All outputs SHALL be registered except drop_ready, which SHALL be decoded from the state.

Reset
REQ-030 While rst=1, asynchronously: state IDLE, board all zero, heights 0, move counter 0, player 01, winner 00, game_over 0, drop_done 0, drop_err 0.
REQ-031 After rst deasserts, the first accept SHALL be possible on the first rising edge.
REQ-032 rst asserted in WRITE or CHECK SHALL abort the drop with no partial board update persisting.

Verification
REQ-033 Reset, then drop col 3 -> board bits[37:36]=01, drop_done 2 cycles after accept, player=10.
REQ-034 Six drops into col 0 alternating players, then a seventh into col 0 -> drop_err pulse, board and player unchanged, bits[11:0]=100110011001.
REQ-035 drop_col=7 -> drop_err pulse, no state change.
REQ-036 Player 1 drops cols 0,0,0,0 interleaved with player 2 on col 1, win_in from the validator -> after the 7th drop game_over=1, winner=01, further drop_valid ignored.
REQ-037 Fill all 42 cells with win_in tied 0 -> game_over=1, winner=00 after the 42nd drop_done.
REQ-038 Assert new_game during WRITE -> no drop_done, board zero, player 01, drop_ready=1 the next cycle.
